// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: redirect requests, program-memory port,
// registered instruction outputs and stack status.
// Optional macro FETCH_STACK_FLAGS_EN adds the sticky stk_ovf/stk_unf flags.
interface fetch_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          stall;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic [AW-1:0] a;
  logic [DW-1:0] rd;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          stack_empty;
  logic          stack_full;
`ifdef FETCH_STACK_FLAGS_EN
  logic          stk_ovf;
  logic          stk_unf;

  // Fetch controller side.
  modport master (
    input  stall, jump, call, ret, target, rd,
    output a, instr, instr_pc, instr_valid, stack_empty, stack_full,
    output stk_ovf, stk_unf
  );

  // Memory / decode side.
  modport slave (
    output stall, jump, call, ret, target, rd,
    input  a, instr, instr_pc, instr_valid, stack_empty, stack_full,
    input  stk_ovf, stk_unf
  );
`else
  // Fetch controller side.
  modport master (
    input  stall, jump, call, ret, target, rd,
    output a, instr, instr_pc, instr_valid, stack_empty, stack_full
  );

  // Memory / decode side.
  modport slave (
    output stall, jump, call, ret, target, rd,
    input  a, instr, instr_pc, instr_valid, stack_empty, stack_full
  );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the program-memory
// address, registers the fetched word, and handles jump/call/ret redirects
// with a small return-address stack. Redirect priority is ret > call > jump.
// Optional macro FETCH_STACK_FLAGS_EN adds sticky overflow/underflow flags.
module fetch_ctrl #(
  parameter int AW    = 10,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fetch_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] pc_reg, pc_next;
  logic [DW-1:0] instr_reg, instr_next;
  logic [AW-1:0] ipc_reg, ipc_next;
  logic          valid_reg, valid_next;
  logic [PW-1:0] sp_reg, sp_next;
  logic [AW-1:0] stack_reg [DEPTH];

  logic          empty, full;
  logic          push_en;
  logic [IW-1:0] push_idx, top_idx;
  logic [AW-1:0] push_data, top_data;
  logic          ovf_set, unf_set;

  assign empty     = (sp_reg == '0);
  assign full      = (sp_reg == PW'(DEPTH));
  // push_idx is only used when not full, so sp fits in IW bits there.
  assign push_idx  = sp_reg[IW-1:0];
  assign top_idx   = IW'(sp_reg - PW'(1));
  assign push_data = ipc_reg + AW'(1);
  assign top_data  = stack_reg[top_idx];

  // Next-state selection: stall freezes everything, then ret > call > jump > fetch.
  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    ipc_next   = ipc_reg;
    valid_next = valid_reg;
    sp_next    = sp_reg;
    push_en    = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        valid_next = 1'b0;
        if (empty) begin
          pc_next = '0;
          unf_set = 1'b1;
        end else begin
          pc_next = top_data;
          sp_next = sp_reg - PW'(1);
        end
      end else if (bus.call) begin
        valid_next = 1'b0;
        pc_next    = bus.target;
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_next = sp_reg + PW'(1);
        end
      end else if (bus.jump) begin
        valid_next = 1'b0;
        pc_next    = bus.target;
      end else begin
        instr_next = bus.rd;
        ipc_next   = pc_reg;
        valid_next = 1'b1;
        pc_next    = pc_reg + AW'(1);
      end
    end
  end

  // PC, instruction register and stack pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= '0;
      instr_reg <= '0;
      ipc_reg   <= '0;
      valid_reg <= 1'b0;
      sp_reg    <= '0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      ipc_reg   <= ipc_next;
      valid_reg <= valid_next;
      sp_reg    <= sp_next;
    end
  end

  // Return-address stack entries; cleared on reset so they never hold X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
    end else if (push_en) begin
      stack_reg[push_idx] <= push_data;
    end
  end

`ifdef FETCH_STACK_FLAGS_EN
  logic ovf_reg, unf_reg;

  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (ovf_set) ovf_reg <= 1'b1;
      if (unf_set) unf_reg <= 1'b1;
    end
  end

  assign bus.stk_ovf = ovf_reg;
  assign bus.stk_unf = unf_reg;
`else
  logic unused_flags;
  assign unused_flags = ovf_set ^ unf_set;
`endif

  assign bus.a           = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = ipc_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by
// random redirect/stall traffic, checked against a queue-based model.
module tb_fetch_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int MSZ   = 1 << AW;

  logic clk;
  logic reset;

  fetch_ctrl_if #(.AW(AW), .DW(DW)) ifc ();

  fetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  logic [DW-1:0] mem [MSZ];
  always_comb ifc.rd = mem[ifc.a];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_pc, m_ipc, m_valid;
  logic [DW-1:0] m_instr;
  int q[$];
  int m_ovf, m_unf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_ipc = 0; m_valid = 0; m_instr = '0;
    q.delete();
    m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_step(input bit st, input bit j, input bit c, input bit r, input int tgt);
    if (st) return;
    if (r) begin
      m_valid = 0;
      if (q.size() > 0) m_pc = q.pop_back();
      else begin m_pc = 0; m_unf = 1; end
    end else if (c) begin
      m_valid = 0;
      if (q.size() < DEPTH) q.push_back((m_ipc + 1) % MSZ);
      else m_ovf = 1;
      m_pc = tgt;
    end else if (j) begin
      m_valid = 0;
      m_pc = tgt;
    end else begin
      m_instr = mem[m_pc];
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % MSZ;
    end
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".a"}, 32'(ifc.a), 32'(m_pc));
    check_val({tag, ".instr"}, 32'(ifc.instr), 32'(m_instr));
    check_val({tag, ".instr_pc"}, 32'(ifc.instr_pc), 32'(m_ipc));
    check_val({tag, ".instr_valid"}, 32'(ifc.instr_valid), 32'(m_valid));
    check_val({tag, ".stack_empty"}, 32'(ifc.stack_empty), 32'(q.size() == 0));
    check_val({tag, ".stack_full"}, 32'(ifc.stack_full), 32'(q.size() == DEPTH));
`ifdef FETCH_STACK_FLAGS_EN
    check_val({tag, ".stk_ovf"}, 32'(ifc.stk_ovf), 32'(m_ovf));
    check_val({tag, ".stk_unf"}, 32'(ifc.stk_unf), 32'(m_unf));
`endif
  endtask

  // One clock edge with the given request inputs; checks after the edge.
  task automatic cyc(input string tag, input bit st, input bit j, input bit c, input bit r, input int tgt);
    ifc.stall  = st;
    ifc.jump   = j;
    ifc.call   = c;
    ifc.ret    = r;
    ifc.target = AW'(tgt);
    model_step(st, j, c, r, tgt);
    @(posedge clk);
    #1;
    $display("cyc %-8s st=%0b j=%0b c=%0b r=%0b tgt=%0d -> a=%0d ipc=%0d v=%0b sp_empty=%0b",
             tag, st, j, c, r, tgt, ifc.a, ifc.instr_pc, ifc.instr_valid, ifc.stack_empty);
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #1 reset = 1'b1;
  endtask

  // Watchdog: the stimulus is fixed-length, so this only fires on a bench hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = DW'(i);
    ifc.stall = 1'b0; ifc.jump = 1'b0; ifc.call = 1'b0; ifc.ret = 1'b0; ifc.target = '0;
    reset = 1'b0;
    model_reset();
    #3;
    check_all("por");
    #1 reset = 1'b1;

    // 1. Sequential fetch.
    for (int i = 0; i < 5; i++) cyc("seq", 0, 0, 0, 0, 0);
    check_val("seq_a_is_5", 32'(ifc.a), 32'd5);
    check_val("seq_ipc_is_4", 32'(ifc.instr_pc), 32'd4);

    // 2. Wrap and stall.
    cyc("jmp1022", 0, 1, 0, 0, 1022);
    cyc("wrap", 0, 0, 0, 0, 0);
    cyc("stall", 1, 1, 1, 1, 5);
    cyc("wrap", 0, 0, 0, 0, 0);
    check_val("wrap_a_is_0", 32'(ifc.a), 32'd0);

    // 3. Call/return from instr_pc = 7.
    do_reset();
    for (int i = 0; i < 8; i++) cyc("seq", 0, 0, 0, 0, 0);
    cyc("call", 0, 0, 1, 0, 100);
    cyc("fetch", 0, 0, 0, 0, 0);
    check_val("call_ipc_100", 32'(ifc.instr_pc), 32'd100);
    cyc("ret", 0, 0, 0, 1, 0);
    cyc("fetch", 0, 0, 0, 0, 0);
    check_val("ret_ipc_8", 32'(ifc.instr_pc), 32'd8);

    // 4. Overflow: five nested calls, then four returns.
    do_reset();
    cyc("seq", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("call", 0, 0, 1, 0, 200 + 100 * i);
      cyc("fetch", 0, 0, 0, 0, 0);
    end
    check_val("ovf_full", 32'(ifc.stack_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc("ret", 0, 0, 0, 1, 0);
      cyc("fetch", 0, 0, 0, 0, 0);
    end

    // 5. Underflow and priority.
    cyc("ret_emp", 0, 0, 0, 1, 0);
    check_val("unf_a_0", 32'(ifc.a), 32'd0);
    cyc("fetch", 0, 0, 0, 0, 0);
    cyc("call", 0, 0, 1, 0, 600);
    cyc("fetch", 0, 0, 0, 0, 0);
    cyc("all3", 0, 1, 1, 1, 700);
    check_val("prio_empty", 32'(ifc.stack_empty), 32'd1);
    cyc("fetch", 0, 0, 0, 0, 0);

    // 6. Async reset during a call flush.
    cyc("call", 0, 0, 1, 0, 333);
    do_reset();
    cyc("fetch", 0, 0, 0, 0, 0);
    check_val("rst_first_ipc", 32'(ifc.instr_pc), 32'd0);

    // Random traffic with random memory contents.
    for (int i = 0; i < MSZ; i++) mem[i] = DW'($urandom);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int unsigned rv;
      bit st, j, c, r;
      rv = $urandom_range(0, 99);
      st = (rv < 20);
      rv = $urandom_range(0, 99);
      j  = (rv < 6);
      rv = $urandom_range(0, 99);
      c  = (rv < 10);
      rv = $urandom_range(0, 99);
      r  = (rv < 9);
      cyc("rnd", st, j, c, r, int'($urandom_range(0, MSZ - 1)));
      if (n == 750) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the simple CPU's program memory (1024 x 16-bit, combinational read). Owns the program counter, drives the memory address, registers the returned word as the current instruction, and services jump/call/return redirects. Call/return uses a small hardware return-address stack. Sits between the program memory and the decode/control unit.

Parameters:
AW, 10, program address width (memory depth 2^AW words)
DW, 16, instruction width
DEPTH, 4, return-address stack entries (>=2); pointer width clog2(DEPTH)+1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  1 = freeze PC, instruction register and stack; redirects are ignored
jump  in  1  redirect: pc <= target
call  in  1  redirect: push instr_pc+1, pc <= target
ret  in  1  redirect: pop, pc <= popped address
target  in  AW  jump/call destination
a  out  AW  program memory address, combinationally equal to pc
rd  in  DW  program memory read data, valid in the same cycle as a
instr  out  DW  registered instruction
instr_pc  out  AW  address that instr was fetched from
instr_valid  out  1  instr holds a live (non-flushed) instruction
stack_empty  out  1  stack pointer == 0
stack_full  out  1  stack pointer == DEPTH

Behaviour:
- Reset (reset=0, async): pc=0, instr=0, instr_pc=0, instr_valid=0, sp=0, all stack entries=0; stack_empty=1, stack_full=0.
- a = pc at all times, with no register stage.
- Edges where stall=1: no state changes, and jump/call/ret are ignored. The requester holds a redirect until stall=0.
- Edges where stall=0 with no redirect (sequential fetch): instr<=rd, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
- PC arithmetic is modulo 2^AW: 1023 wraps to 0 with no flag.
- Redirect priority when several are asserted: ret > call > jump. Only the winner takes effect.
- On any redirect edge, instr and instr_pc hold their values and instr_valid<=0 (flush). The next unstalled edge fetches from the new pc. Redirect-to-valid-instruction latency is 2 edges.
- jump: pc<=target.
- call, stack not full: stack[sp]<=instr_pc+1 (mod 2^AW), sp<=sp+1, pc<=target.
- call, stack full: the push is dropped, sp and entries are unchanged, and pc<=target still happens.
- ret, stack not empty: pc<=stack[sp-1], sp<=sp-1.
- ret, stack empty: pc<=0, sp stays 0.
- call and ret on the same edge: ret wins and call is ignored, so there is no simultaneous push/pop.
- Redirects are edge-sampled levels. A request held high for N unstalled cycles acts N times, so the requester pulses it for exactly 1 unstalled cycle.
- Reset asserted mid-redirect or while stalled returns all state immediately to reset values. The first fetch after release reads address 0.

Optional Feature:
FETCH_STACK_FLAGS_EN
- When defined, adds two outputs. stk_ovf (1 bit) is set sticky on a call while stack_full. stk_unf (1 bit) is set sticky on a ret while stack_empty. Both are cleared only by reset, with reset value 0.
- When not defined, these ports and their registers do not exist. Overflow and underflow behave exactly as in Behaviour, silently.

Test Plan:
1. Sequential fetch: memory word at each address = address value. Release reset, no stall, 5 edges. Expect instr = 0,1,2,3,4, instr_pc matching, instr_valid=1 from edge 1, a=5.
2. Wrap and stall: force pc to 1022 via jump target=1022. Run 3 edges, stalling on the middle one. Expect instr_pc 1022, 1022 (held), 1023, then a=0.
3. Call/return: at instr_pc=7, pulse call with target=100. Expect instr_valid=0 next edge, then instr_pc=100. Pulse ret. Expect flush, then instr_pc=8; sp back to 0.
4. Stack overflow: 5 nested calls with DEPTH=4. Expect stack_full after the 4th call; the 5th still jumps but pushes nothing. 4 rets return to the 4 stored addresses in LIFO order. With FETCH_STACK_FLAGS_EN, expect stk_ovf=1 held.
5. Underflow and priority: ret with empty stack. Expect pc=0 and stk_unf=1 (if enabled). Assert jump=1, call=1, ret=1 together with 1 entry on the stack. Expect the pop target only, and sp decremented.
6. Async reset mid-run: drop reset between edges during a call flush. Expect all outputs at reset values immediately. After release, the first instr equals mem[0].
